// File: rtl/preg_free_list.sv
// Circular free list of physical register indices for rename.
// Speculative head serves allocation; commit head lets a flush restore it in one cycle.
module preg_free_list #(
  parameter int unsigned PREG_NUM      = 128,
  parameter int unsigned AREG_NUM      = 32,
  parameter int unsigned ALLOC_WIDTH   = 4,
  parameter int unsigned RELEASE_WIDTH = 4,
  parameter int unsigned COMMIT_WIDTH  = 4
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         alloc_valid,
  input  logic [$clog2(ALLOC_WIDTH+1)-1:0]             alloc_num,
  output logic                                         alloc_ready,
  output logic [ALLOC_WIDTH*$clog2(PREG_NUM)-1:0]      alloc_preg,
  input  logic [RELEASE_WIDTH-1:0]                     rel_valid,
  input  logic [RELEASE_WIDTH*$clog2(PREG_NUM)-1:0]    rel_preg,
  input  logic [$clog2(COMMIT_WIDTH+1)-1:0]            commit_num,
  input  logic                                         flush,
  output logic [$clog2(PREG_NUM-AREG_NUM+1)-1:0]       free_count,
  output logic                                         error
);

  localparam int unsigned FREE_NUM = PREG_NUM - AREG_NUM;
  localparam int unsigned PW       = $clog2(PREG_NUM);
  localparam int unsigned CW       = $clog2(FREE_NUM + 1);
  localparam int unsigned AN_W     = $clog2(ALLOC_WIDTH + 1);
  localparam int unsigned RC_W     = $clog2(RELEASE_WIDTH + 1);
  localparam int unsigned PTR_W    = $clog2(FREE_NUM);
  localparam int unsigned EXT_W    = CW + 2;

  logic [PW-1:0]    entry_q [FREE_NUM];
  logic [PTR_W-1:0] head_q, commit_head_q, tail_q;
  logic [PTR_W-1:0] head_d, commit_head_d, tail_d;
  logic [CW-1:0]    spec_count_q, arch_count_q;
  logic [CW-1:0]    spec_count_d, arch_count_d;
  logic             error_q, error_d;
  logic             fire;
  logic [RC_W-1:0]  rel_cnt;
  logic [PTR_W-1:0] rel_idx [RELEASE_WIDTH];
  logic [EXT_W-1:0] arch_ext, spec_ext;

  // Pointer increment with explicit wrap; FREE_NUM need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [PTR_W-1:0] inc);
    logic [PTR_W:0] s;
    s = {1'b0, p} + {1'b0, inc};
    if (s >= (PTR_W+1)'(FREE_NUM)) s = s - (PTR_W+1)'(FREE_NUM);
    return s[PTR_W-1:0];
  endfunction

  // Allocation lanes read straight from registered state.
  always_comb begin
    alloc_preg  = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      alloc_preg[i*PW +: PW] = entry_q[ptr_add(head_q, PTR_W'(i))];
    end
    alloc_ready = !flush && (EXT_W'(spec_count_q) >= EXT_W'(alloc_num));
  end

  // Compact the sparse release strobes onto consecutive tail slots.
  always_comb begin
    rel_cnt = '0;
    for (int l = 0; l < RELEASE_WIDTH; l++) begin
      rel_idx[l] = ptr_add(tail_q, PTR_W'(rel_cnt));
      if (rel_valid[l]) rel_cnt = rel_cnt + RC_W'(1);
    end
  end

  always_comb begin
    fire          = alloc_valid && alloc_ready;
    commit_head_d = ptr_add(commit_head_q, PTR_W'(commit_num));
    tail_d        = ptr_add(tail_q, PTR_W'(rel_cnt));
    arch_ext      = EXT_W'(arch_count_q) + EXT_W'(rel_cnt) - EXT_W'(commit_num);
    spec_ext      = EXT_W'(spec_count_q) + EXT_W'(rel_cnt)
                    - (fire ? EXT_W'(alloc_num) : EXT_W'(0));
    head_d        = head_q;
    if (flush)     head_d = commit_head_d;
    else if (fire) head_d = ptr_add(head_q, PTR_W'(alloc_num));
    arch_count_d  = CW'(arch_ext);
    spec_count_d  = flush ? CW'(arch_ext) : CW'(spec_ext);
    error_d       = error_q
                    | (EXT_W'(rel_cnt) > EXT_W'(FREE_NUM) - EXT_W'(arch_count_q))
                    | (EXT_W'(commit_num) > EXT_W'(arch_count_q) - EXT_W'(spec_count_q))
                    | (alloc_valid && (alloc_num > AN_W'(ALLOC_WIDTH)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FREE_NUM; i++) entry_q[i] <= PW'(AREG_NUM + i);
      head_q        <= '0;
      commit_head_q <= '0;
      tail_q        <= '0;
      spec_count_q  <= CW'(FREE_NUM);
      arch_count_q  <= CW'(FREE_NUM);
      error_q       <= 1'b0;
    end else begin
      for (int l = 0; l < RELEASE_WIDTH; l++) begin
        if (rel_valid[l]) entry_q[rel_idx[l]] <= rel_preg[l*PW +: PW];
      end
      head_q        <= head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      spec_count_q  <= spec_count_d;
      arch_count_q  <= arch_count_d;
      error_q       <= error_d;
    end
  end

  assign free_count = spec_count_q;
  assign error      = error_q;

endmodule

// File: tb/tb_preg_free_list.sv
// Directed bench for preg_free_list: allocation, wrap, release ordering, flush and error handling.
module tb_preg_free_list;

  localparam int unsigned PREG_NUM = 128;
  localparam int unsigned AREG_NUM = 32;
  localparam int unsigned AW       = 4;
  localparam int unsigned RW       = 4;
  localparam int unsigned CMW      = 4;
  localparam int unsigned PW       = $clog2(PREG_NUM);
  localparam int unsigned CW       = $clog2(PREG_NUM - AREG_NUM + 1);

  logic                   clk;
  logic                   reset;
  logic                   alloc_valid;
  logic [$clog2(AW+1)-1:0] alloc_num;
  logic                   alloc_ready;
  logic [AW*PW-1:0]       alloc_preg;
  logic [RW-1:0]          rel_valid;
  logic [RW*PW-1:0]       rel_preg;
  logic [$clog2(CMW+1)-1:0] commit_num;
  logic                   flush;
  logic [CW-1:0]          free_count;
  logic                   error;

  int checks   = 0;
  int failures = 0;

  preg_free_list dut (
    .clk         (clk),
    .reset       (reset),
    .alloc_valid (alloc_valid),
    .alloc_num   (alloc_num),
    .alloc_ready (alloc_ready),
    .alloc_preg  (alloc_preg),
    .rel_valid   (rel_valid),
    .rel_preg    (rel_preg),
    .commit_num  (commit_num),
    .flush       (flush),
    .free_count  (free_count),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    alloc_num   = '0;
    rel_valid   = '0;
    rel_preg    = '0;
    commit_num  = '0;
    flush       = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane(input int i);
    return 32'(alloc_preg[i*PW +: PW]);
  endfunction

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    #1;
    chk("rst_free_count", 32'(free_count), 96);
    chk("rst_error", 32'(error), 0);
    chk("rst_ready_num0", 32'(alloc_ready), 1);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_lane%0d", i), lane(i), 32 + i);

    // First allocation of four
    alloc_valid = 1'b1; alloc_num = 4;
    #1;
    chk("s1_ready", 32'(alloc_ready), 1);
    for (int i = 0; i < 4; i++) chk($sformatf("s1_lane%0d", i), lane(i), 32 + i);
    tick();
    idle();
    chk("s1_free_count", 32'(free_count), 92);
    chk("s1_lane0_next", lane(0), 36);

    // Drain the whole list; head wraps to slot 0
    do_reset();
    alloc_valid = 1'b1; alloc_num = 4;
    repeat (24) tick();
    idle();
    chk("s2_free_count", 32'(free_count), 0);
    alloc_num = 1;
    #1;
    chk("s2_ready_num1", 32'(alloc_ready), 0);
    alloc_num = 0;
    #1;
    chk("s2_ready_num0", 32'(alloc_ready), 1);
    chk("s2_head_wrap_lane0", lane(0), 32);
    chk("s2_error", 32'(error), 0);
    commit_num = 4;
    tick();
    idle();
    chk("s2_commit_error", 32'(error), 0);

    // Sparse release into the empty list keeps lane order
    rel_valid = 4'b1010;
    rel_preg  = {PW'(7), PW'(0), PW'(5), PW'(0)};
    #1;
    chk("s3_not_visible_yet", 32'(free_count), 0);
    tick();
    idle();
    chk("s3_free_count", 32'(free_count), 2);
    chk("s3_lane0", lane(0), 5);
    chk("s3_lane1", lane(1), 7);
    chk("s3_error", 32'(error), 0);

    // Fill to four (exactly at the release limit), commit, then allocate and release together
    rel_valid = 4'b0101;
    rel_preg  = {PW'(0), PW'(11), PW'(0), PW'(9)};
    tick();
    idle();
    commit_num = 4;
    tick();
    idle();
    chk("s4_free_count_pre", 32'(free_count), 4);
    chk("s4_error_pre", 32'(error), 0);
    alloc_valid = 1'b1; alloc_num = 4;
    rel_valid   = 4'b0011;
    rel_preg    = {PW'(0), PW'(0), PW'(21), PW'(20)};
    #1;
    chk("s4_ready", 32'(alloc_ready), 1);
    chk("s4_grant0", lane(0), 5);
    chk("s4_grant1", lane(1), 7);
    chk("s4_grant2", lane(2), 9);
    chk("s4_grant3", lane(3), 11);
    tick();
    idle();
    chk("s4_free_count", 32'(free_count), 2);
    chk("s4_lane0", lane(0), 20);
    chk("s4_lane1", lane(1), 21);
    chk("s4_error", 32'(error), 0);

    // Commit three of eight allocations, then flush back to the commit head
    do_reset();
    alloc_valid = 1'b1; alloc_num = 4;
    tick();
    chk("s5_lane0_second", lane(0), 36);
    tick();
    idle();
    chk("s5_free_after_allocs", 32'(free_count), 88);
    commit_num = 3;
    tick();
    idle();
    flush = 1'b1; alloc_valid = 1'b1; alloc_num = 4;
    #1;
    chk("s5_ready_during_flush", 32'(alloc_ready), 0);
    tick();
    idle();
    chk("s5_free_count", 32'(free_count), 93);
    for (int i = 0; i < 4; i++) chk($sformatf("s5_lane%0d", i), lane(i), 35 + i);
    chk("s5_error", 32'(error), 0);

    // Release into a full list is an overflow; sticky until asynchronous reset
    do_reset();
    chk("s6_free_count_full", 32'(free_count), 96);
    rel_valid = 4'b0001;
    rel_preg  = {PW'(0), PW'(0), PW'(0), PW'(40)};
    tick();
    idle();
    chk("s6_error_set", 32'(error), 1);
    repeat (3) tick();
    chk("s6_error_held", 32'(error), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("s6_async_error", 32'(error), 0);
    chk("s6_async_free_count", 32'(free_count), 96);
    chk("s6_async_lane0", lane(0), 32);
    tick();
    reset = 1'b0;

    // Oversized allocation request
    alloc_valid = 1'b1; alloc_num = 5;
    tick();
    idle();
    chk("err_alloc_num", 32'(error), 1);

    // Commit with nothing outstanding
    do_reset();
    chk("err_cleared", 32'(error), 0);
    commit_num = 1;
    tick();
    idle();
    chk("err_commit", 32'(error), 1);

    do_reset();
    chk("final_error", 32'(error), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/preg_free_list.md
Name: preg_free_list

Overview:
- Multi-port circular free list of physical register indices for the rename stage, parametrised over physical/architectural register counts and per-cycle allocate/release/commit widths.
- Hands out up to ALLOC_WIDTH free pregs per cycle to rename.
- Accepts up to RELEASE_WIDTH freed pregs per cycle from retire.
- Keeps a committed head pointer so a pipeline flush restores the speculative head in one cycle.

Parameters:
- PREG_NUM, 128, number of physical registers.
- AREG_NUM, 32, architectural registers; pregs 0..AREG_NUM-1 are mapped at reset and never start in the list.
- ALLOC_WIDTH, 4, maximum allocations per cycle; equals MACHINE_WIDTH.
- RELEASE_WIDTH, 4, maximum releases per cycle.
- COMMIT_WIDTH, 4, maximum committed allocations per cycle.
- Derived: FREE_NUM = PREG_NUM-AREG_NUM; PW = $clog2(PREG_NUM); CW = $clog2(FREE_NUM+1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- alloc_valid  in  1  rename requests allocation this cycle.
- alloc_num  in  $clog2(ALLOC_WIDTH+1)  number of pregs requested.
- alloc_ready  out  1  request can be satisfied in full.
- alloc_preg  out  ALLOC_WIDTH*PW  lane i = i-th preg handed out; lane 0 in the LSBs.
- rel_valid  in  RELEASE_WIDTH  per-lane release strobe; any bit pattern allowed.
- rel_preg  in  RELEASE_WIDTH*PW  released preg per lane.
- commit_num  in  $clog2(COMMIT_WIDTH+1)  allocations becoming architectural this cycle.
- flush  in  1  squash all uncommitted allocations.
- free_count  out  CW  registered speculative free count.
- error  out  1  sticky protocol-violation flag.

Behaviour:
- Storage: FREE_NUM entries of PW bits. Pointers head, commit_head and tail each range 0..FREE_NUM-1 and wrap modulo FREE_NUM. FREE_NUM need not be a power of two, so wrap is explicit (subtract FREE_NUM on overflow).
- Counters:
  - spec_count: entries from head to tail.
  - arch_count: entries from commit_head to tail.
  - Invariant: spec_count <= arch_count <= FREE_NUM.
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - entry[i] = AREG_NUM+i.
  - head = commit_head = tail = 0.
  - spec_count = arch_count = FREE_NUM.
  - error = 0; free_count = FREE_NUM.
  - alloc_preg = AREG_NUM..AREG_NUM+ALLOC_WIDTH-1.
- alloc_preg lane i = entry[(head+i) mod FREE_NUM]. It is driven combinationally from registered state, so it has zero latency. Lanes >= alloc_num are don't-care.
- alloc_ready = !flush && (spec_count >= alloc_num). alloc_num = 0 gives ready = 1.
- fire = alloc_valid && alloc_ready.
  - On fire: head += alloc_num.
  - No partial grants.
- Release:
  - rel_cnt = popcount(rel_valid).
  - The k-th set bit, in ascending lane order, writes its preg to entry[(tail+k) mod FREE_NUM].
  - tail += rel_cnt.
  - Releases are visible to alloc_ready and alloc_preg from the next cycle only.
- Commit: commit_head += commit_num.
- Counter update, same cycle:
  - spec_count += rel_cnt - (fire ? alloc_num : 0).
  - arch_count += rel_cnt - commit_num.
- Flush:
  - head <= commit_head + commit_num, i.e. the same-cycle commit is applied first.
  - spec_count <= the updated arch_count.
  - Same-cycle releases are still written and counted.
  - No allocation fires while flush = 1.
- free_count = spec_count (registered).
- error is set, and held until reset, when any of:
  - rel_cnt > FREE_NUM - arch_count (release overflow).
  - commit_num > arch_count - spec_count (commit beyond outstanding allocations).
  - alloc_valid with alloc_num > ALLOC_WIDTH.
- After error is set, list contents are unspecified until reset.

Test Plan:
1. Reset, then alloc_valid=1, alloc_num=4 → alloc_ready=1, alloc_preg={35,34,33,32}. Next cycle free_count=92 and lane 0=36.
2. 24 consecutive allocs of 4 → free_count=0. Then alloc_num=1 → alloc_ready=0; alloc_num=0 → alloc_ready=1. head wraps to 0 with no error.
3. From the empty state of scenario 2 (free_count=0), rel_valid=4'b1010 with lane1=5, lane3=7 → next cycle free_count=2, alloc_preg lane0=5, lane1=7 (order preserved after wrap). No error.
4. free_count=4, alloc 4 and release 2 in the same cycle → alloc_ready=1, granted pregs are the old head entries, next free_count=2.
5. After reset, alloc 4 twice (32..39), commit_num=3, then flush with commit_num=0 → next free_count=93, alloc_preg lane0..3=35,36,37,38.
6. Release one preg while free_count=96 → error=1 and stays 1. Assert reset mid-run → error=0, free_count=96, alloc_preg lane0=32.
